proc_scycle: RTL and testbench

Single-cycle TinyRV1 processor core: fetches, decodes, executes and retires one instruction per clock. It connects to a combinational instruction port and a data memory port, exposes three input and three output I/O registers, and emits a per-instruction retirement trace for verification.

---
 rtl/proc_scycle_pkg.sv | 45 ++++
 rtl/proc_scycle_regfile.sv | 23 ++
 rtl/proc_scycle.sv | 191 +++++++++++++++++++
 tb/tb_proc_scycle.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_scycle_pkg.sv
// Shared decode constants, control enums and immediate generator for the
// proc_scycle single-cycle TinyRV1 core.
package proc_scycle_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_LSW  = 3'b010;
  localparam logic [2:0] F3_JR   = 3'b000;
  localparam logic [2:0] F3_CSRW = 3'b001;
  localparam logic [2:0] F3_CSRR = 3'b010;
  localparam logic [6:0] F7_ADD  = 7'b0000000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [11:0] CSR_IN0  = 12'hFC2;
  localparam logic [11:0] CSR_IN1  = 12'hFC3;
  localparam logic [11:0] CSR_IN2  = 12'hFC4;
  localparam logic [11:0] CSR_OUT0 = 12'h7C2;
  localparam logic [11:0] CSR_OUT1 = 12'h7C3;
  localparam logic [11:0] CSR_OUT2 = 12'h7C4;

  typedef enum logic [1:0] {PC_PLUS4, PC_BR, PC_JAL, PC_JR} pc_sel_e;
  typedef enum logic [2:0] {WB_ALU, WB_MUL, WB_MEM, WB_PC4, WB_CSR} wb_sel_e;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_type_e;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_e sel);
    logic [31:0] imm;
    unique case (sel)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/proc_scycle_regfile.sv
// 32 x 32-bit register file, two asynchronous reads and one synchronous write;
// x0 always reads zero and ignores writes.
module proc_scycle_regfile (
  input  logic        clk,
  input  logic        wen_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr0_i,
  output logic [31:0] rdata0_o,
  input  logic [4:0]  raddr1_i,
  output logic [31:0] rdata1_o
);

  logic [31:0] rf_q [32];

  always_ff @(posedge clk) begin
    if (wen_i && (waddr_i != 5'd0)) rf_q[waddr_i] <= wdata_i;
  end

  assign rdata0_o = (raddr0_i == 5'd0) ? 32'd0 : rf_q[raddr0_i];
  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : rf_q[raddr1_i];

endmodule

// File: rtl/proc_scycle.sv
// Single-cycle TinyRV1 core: fetch, decode, execute and retire one instruction
// per clock. Define PROC_SCYCLE_TRACE_EN to drive the retirement trace port.
module proc_scycle
  import proc_scycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imemreq_val,
  output logic [31:0] imemreq_addr,
  input  logic [31:0] imemresp_data,
  output logic        dmemreq_val,
  output logic        dmemreq_type,
  output logic [31:0] dmemreq_addr,
  output logic [31:0] dmemreq_wdata,
  input  logic [31:0] dmemresp_rdata,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [31:0] out2,
  output logic        trace_val,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d;
  logic [31:0] instr, rs1_data, rs2_data, imm, alu_out, mul_out, pc_plus4, br_tgt;
  logic [31:0] csr_rdata, wb_data;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [11:0] csr_num;
  pc_sel_e     pc_sel;
  wb_sel_e     wb_sel;
  imm_type_e   imm_sel;
  logic        use_rs2, rf_wen_dec, mem_val, mem_wr, csr_wr;

  assign instr   = imemresp_data;
  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign csr_num = instr[31:20];

  proc_scycle_regfile u_regfile (
    .clk      (clk),
    .wen_i    (rf_wen_dec & rst),
    .waddr_i  (instr[11:7]),
    .wdata_i  (wb_data),
    .raddr0_i (instr[19:15]),
    .rdata0_o (rs1_data),
    .raddr1_i (instr[24:20]),
    .rdata1_o (rs2_data)
  );

  // Unrecognised encodings keep every default: fall through to PC+4 with no writes.
  always_comb begin
    pc_sel     = PC_PLUS4;
    wb_sel     = WB_ALU;
    imm_sel    = IMM_I;
    use_rs2    = 1'b0;
    rf_wen_dec = 1'b0;
    mem_val    = 1'b0;
    mem_wr     = 1'b0;
    csr_wr     = 1'b0;
    case (opcode)
      OPC_OP: if (funct3 == F3_ADD) begin
        if (funct7 == F7_ADD) begin
          rf_wen_dec = 1'b1;
          use_rs2    = 1'b1;
        end else if (funct7 == F7_MUL) begin
          rf_wen_dec = 1'b1;
          wb_sel     = WB_MUL;
        end
      end
      OPC_OPIMM: if (funct3 == F3_ADD) rf_wen_dec = 1'b1;
      OPC_LOAD: if (funct3 == F3_LSW) begin
        mem_val    = 1'b1;
        rf_wen_dec = 1'b1;
        wb_sel     = WB_MEM;
      end
      OPC_STORE: if (funct3 == F3_LSW) begin
        mem_val = 1'b1;
        mem_wr  = 1'b1;
        imm_sel = IMM_S;
      end
      OPC_JAL: begin
        rf_wen_dec = 1'b1;
        wb_sel     = WB_PC4;
        pc_sel     = PC_JAL;
        imm_sel    = IMM_J;
      end
      OPC_JALR: if (funct3 == F3_JR) pc_sel = PC_JR;
      OPC_BRANCH: if (funct3 == F3_BNE) begin
        imm_sel = IMM_B;
        if (rs1_data != rs2_data) pc_sel = PC_BR;
      end
      OPC_SYSTEM: begin
        if (funct3 == F3_CSRR) begin
          rf_wen_dec = 1'b1;
          wb_sel     = WB_CSR;
        end else if (funct3 == F3_CSRW) begin
          csr_wr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign imm      = gen_imm(instr, imm_sel);
  assign alu_out  = rs1_data + (use_rs2 ? rs2_data : imm);
  assign mul_out  = rs1_data * rs2_data;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_q + imm;

  always_comb begin
    unique case (pc_sel)
      PC_BR, PC_JAL: pc_d = br_tgt;
      PC_JR:         pc_d = rs1_data;
      default:       pc_d = pc_plus4;
    endcase
  end

  always_comb begin
    case (csr_num)
      CSR_IN0: csr_rdata = in0;
      CSR_IN1: csr_rdata = in1;
      CSR_IN2: csr_rdata = in2;
      default: csr_rdata = 32'd0;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WB_MUL:  wb_data = mul_out;
      WB_MEM:  wb_data = dmemresp_rdata;
      WB_PC4:  wb_data = pc_plus4;
      WB_CSR:  wb_data = csr_rdata;
      default: wb_data = alu_out;
    endcase
  end

  always_comb begin
    out0_d = out0_q;
    out1_d = out1_q;
    out2_d = out2_q;
    if (csr_wr) begin
      case (csr_num)
        CSR_OUT0: out0_d = rs1_data;
        CSR_OUT1: out1_d = rs1_data;
        CSR_OUT2: out2_d = rs1_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= 32'd0;
      out0_q <= 32'd0;
      out1_q <= 32'd0;
      out2_q <= 32'd0;
    end else begin
      pc_q   <= pc_d;
      out0_q <= out0_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
    end
  end

  assign imemreq_val   = rst;
  assign imemreq_addr  = pc_q;
  assign dmemreq_val   = mem_val & rst;
  assign dmemreq_type  = mem_wr;
  assign dmemreq_addr  = alu_out;
  assign dmemreq_wdata = rs2_data;
  assign out0 = out0_q;
  assign out1 = out1_q;
  assign out2 = out2_q;

`ifdef PROC_SCYCLE_TRACE_EN
  assign trace_val  = rst;
  assign trace_addr = pc_q;
  assign trace_data = rf_wen_dec ? wb_data : 'x;
`else
  assign trace_val  = 1'b0;
  assign trace_addr = 32'd0;
  assign trace_data = 32'd0;
`endif

endmodule

// File: tb/tb_proc_scycle.sv
// Self-checking bench for proc_scycle: an instruction-level reference model
// checked every cycle, directed programs with literal expectations, random programs.
module tb_proc_scycle;

  logic        clk, rst;
  logic        imemreq_val, dmemreq_val, dmemreq_type, trace_val;
  logic [31:0] imemreq_addr, imemresp_data, dmemreq_addr, dmemreq_wdata, dmemresp_rdata;
  logic [31:0] in0, in1, in2, out0, out1, out2, trace_addr, trace_data;

  proc_scycle dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
    .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
    .in0(in0), .in1(in1), .in2(in2), .out0(out0), .out1(out1), .out2(out2),
    .trace_val(trace_val), .trace_addr(trace_addr), .trace_data(trace_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [128];
  logic [31:0] dmem [256];
  assign imemresp_data  = imem[imemreq_addr[8:2]];
  assign dmemresp_rdata = dmem[dmemreq_addr[9:2]];
  always @(posedge clk) if (dmemreq_val && dmemreq_type) dmem[dmemreq_addr[9:2]] <= dmemreq_wdata;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endfunction

  // instruction encoders
  function automatic logic [31:0] e_addi(input logic [31:0] rd, rs1, imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'h13};
  endfunction
  function automatic logic [31:0] e_r(input logic [31:0] f7, rd, rs1, rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] e_lw(input logic [31:0] rd, rs1, imm);
    return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'h03};
  endfunction
  function automatic logic [31:0] e_sw(input logic [31:0] rs2, rs1, imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_bne(input logic [31:0] rs1, rs2, imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b001, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_jal(input logic [31:0] rd, imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] e_jr(input logic [31:0] rs1);
    return {12'd0, rs1[4:0], 3'b000, 5'd0, 7'h67};
  endfunction
  function automatic logic [31:0] e_csrr(input logic [31:0] rd, csr);
    return {csr[11:0], 5'd0, 3'b010, rd[4:0], 7'h73};
  endfunction
  function automatic logic [31:0] e_csrw(input logic [31:0] csr, rs1);
    return {csr[11:0], rs1[4:0], 3'b001, 5'd0, 7'h73};
  endfunction
  localparam logic [31:0] NOP = 32'h00000013;

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [256];
  logic [31:0] m_out  [3];
  logic [31:0] m_pc;
  bit          m_known = 0;

  always @(negedge clk) begin : cmp
    logic [31:0] ins, a, b, npc, wbd, ea, ii, is, ib, ij;
    logic [11:0] csr;
    bit wb, mv, mw;
    int oidx;
    if (!rst) begin
      chk("imem_val_in_reset", {31'd0, imemreq_val}, 32'd0);
      chk("dmem_val_in_reset", {31'd0, dmemreq_val}, 32'd0);
      chk("trace_val_in_reset", {31'd0, trace_val}, 32'd0);
      m_pc = 0; m_out[0] = 0; m_out[1] = 0; m_out[2] = 0; m_known = 1;
    end else if (m_known) begin
      ins = imem[m_pc[8:2]];
      a = m_regs[ins[19:15]]; b = m_regs[ins[24:20]];
      ii = 32'($signed(ins[31:20]));
      is = 32'($signed({ins[31:25], ins[11:7]}));
      ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      csr = ins[31:20];
      npc = m_pc + 4; wb = 0; wbd = 0; mv = 0; mw = 0; ea = 0; oidx = -1;
      if (ins[6:0] == 7'h33 && ins[14:12] == 0 && ins[31:25] == 0) begin wb = 1; wbd = a + b; end
      else if (ins[6:0] == 7'h33 && ins[14:12] == 0 && ins[31:25] == 1) begin wb = 1; wbd = a * b; end
      else if (ins[6:0] == 7'h13 && ins[14:12] == 0) begin wb = 1; wbd = a + ii; end
      else if (ins[6:0] == 7'h03 && ins[14:12] == 2) begin mv = 1; ea = a + ii; wb = 1; wbd = m_mem[ea[9:2]]; end
      else if (ins[6:0] == 7'h23 && ins[14:12] == 2) begin mv = 1; mw = 1; ea = a + is; end
      else if (ins[6:0] == 7'h6f) begin wb = 1; wbd = m_pc + 4; npc = m_pc + ij; end
      else if (ins[6:0] == 7'h67 && ins[14:12] == 0) npc = a;
      else if (ins[6:0] == 7'h63 && ins[14:12] == 1) begin if (a != b) npc = m_pc + ib; end
      else if (ins[6:0] == 7'h73 && ins[14:12] == 2) begin
        wb = 1;
        wbd = (csr == 12'hFC2) ? in0 : (csr == 12'hFC3) ? in1 : (csr == 12'hFC4) ? in2 : 32'd0;
      end
      else if (ins[6:0] == 7'h73 && ins[14:12] == 1) begin
        if (csr >= 12'h7C2 && csr <= 12'h7C4) oidx = int'(csr - 12'h7C2);
      end
      chk("imemreq_val", {31'd0, imemreq_val}, 32'd1);
      chk("pc", imemreq_addr, m_pc);
      chk("dmemreq_val", {31'd0, dmemreq_val}, {31'd0, mv});
      if (mv) begin
        chk("dmemreq_type", {31'd0, dmemreq_type}, {31'd0, mw});
        chk("dmemreq_addr", dmemreq_addr, ea);
        if (mw) chk("dmemreq_wdata", dmemreq_wdata, b);
      end
      chk("out0", out0, m_out[0]);
      chk("out1", out1, m_out[1]);
      chk("out2", out2, m_out[2]);
`ifdef PROC_SCYCLE_TRACE_EN
      chk("trace_val", {31'd0, trace_val}, 32'd1);
      chk("trace_addr", trace_addr, m_pc);
      if (wb) chk("trace_data", trace_data, wbd);
`else
      chk("trace_tied", {trace_val, trace_addr[30:0]} | trace_data, 32'd0);
`endif
      if (wb && ins[11:7] != 0) m_regs[ins[11:7]] = wbd;
      if (mw) m_mem[ea[9:2]] = b;
      if (oidx >= 0) m_out[oidx] = a;
      m_pc = npc;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] prog [$];
  bit rand_in = 1;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_in) begin in0 = $urandom; in1 = $urandom; in2 = $urandom; end
  endtask

  // hold reset, load prog (rest filled with nops), release; instruction at 0 then executes
  task automatic start_prog();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 128; i++) imem[i] = (i < prog.size()) ? prog[i] : NOP;
    tick();
    rst = 1'b1;
  endtask

  task automatic check_pc_now(input string nm, input logic [31:0] exp);
    @(negedge clk);
    chk(nm, imemreq_addr, exp);
  endtask

  initial begin
    rst = 1'b0; in0 = 0; in1 = 0; in2 = 0;
    m_regs[0] = 0;
    for (int i = 1; i < 32; i++) m_regs[i] = 'x;
    for (int i = 0; i < 256; i++) begin dmem[i] = $urandom; m_mem[i] = dmem[i]; end
    for (int i = 0; i < 128; i++) imem[i] = NOP;
    tick(); tick();

    // taken bne
    prog = '{e_addi(1, 0, 1), e_bne(1, 0, 8)};
    start_prog(); tick(); tick();
    check_pc_now("bne_taken_pc", 32'h0000000C);

    // not-taken bne
    prog = '{e_addi(1, 0, 0), e_bne(1, 0, 8)};
    start_prog(); tick(); tick();
    check_pc_now("bne_not_taken_pc", 32'h00000008);

    // countdown loop exits after seven instructions
    prog = '{e_addi(1, 0, 3), e_addi(1, 1, -1), e_bne(1, 0, -4)};
    start_prog();
    for (int i = 0; i < 7; i++) tick();
    check_pc_now("loop_exit_pc", 32'h0000000C);

    // load/store
    dmem[64] = 32'hCAFE0000; m_mem[64] = 32'hCAFE0000;
    prog = '{e_addi(2, 0, 32'h100), e_lw(3, 2, 0), e_sw(3, 2, 4)};
    start_prog(); tick(); tick(); tick();
    chk("mem_0x104", dmem[65], 32'hCAFE0000);

    // jal, csrr, csrw, then reset mid-run clears outputs
    rand_in = 0; in0 = 32'd7;
    prog = '{e_jal(1, 8), NOP, e_csrr(5, 32'hFC2), e_csrw(32'h7C3, 5), e_csrw(32'h7C2, 1)};
    start_prog(); tick();
    check_pc_now("jal_target_pc", 32'h00000008);
    tick(); tick(); tick();
    @(negedge clk);
    chk("out1_from_in0", out1, 32'd7);
    chk("out0_link", out0, 32'd4);
    rand_in = 1;
    tick();
    rst = 1'b0; tick(); rst = 1'b1;
    check_pc_now("reset_pc", 32'd0);
    chk("reset_out1", out1, 32'd0);
    chk("reset_out0", out0, 32'd0);

    // reset in the middle of the loop restarts it
    prog = '{e_addi(1, 0, 3), e_addi(1, 1, -1), e_bne(1, 0, -4)};
    start_prog(); tick(); tick(); tick();
    rst = 1'b0; tick(); rst = 1'b1;
    check_pc_now("loop_reset_pc", 32'd0);
    for (int i = 0; i < 7; i++) tick();
    check_pc_now("loop_reset_exit_pc", 32'h0000000C);

    // random programs: registers initialised by a prefix, then random mix
    for (int p = 0; p < 8; p++) begin
      prog.delete();
      for (int r = 1; r < 32; r++) prog.push_back(e_addi(r, 0, $urandom));
      for (int k = 31; k < 128; k++) begin
        logic [31:0] off, w;
        off = 32'($signed($urandom_range(1, 16))) * ($urandom_range(0, 1) ? 4 : -4);
        case ($urandom_range(0, 10))
          0: w = e_r(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
          1: w = e_r(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
          2: w = e_addi($urandom_range(0, 31), $urandom_range(0, 31), $urandom);
          3: w = e_lw($urandom_range(0, 31), $urandom_range(0, 31), $urandom);
          4: w = e_sw($urandom_range(0, 31), $urandom_range(0, 31), $urandom);
          5: w = e_bne($urandom_range(0, 31), $urandom_range(0, 31), off);
          6: w = e_jal($urandom_range(0, 31), off);
          7: w = e_jr($urandom_range(0, 31));
          8: w = e_csrr($urandom_range(0, 31), 32'hFC2 + $urandom_range(0, 3));
          9: w = e_csrw(32'h7C2 + $urandom_range(0, 3), $urandom_range(0, 31));
          default: w = {$urandom_range(0, 32'h1FFFFFF), 7'b0001111};
        endcase
        prog.push_back(w);
      end
      start_prog();
      for (int c = 0; c < 400; c++) begin
        tick();
        rst = ($urandom_range(0, 79) != 0);
      end
    end

    rst = 1'b0; tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
